dpad_to_analog: RTL and testbench
=================================

Name: dpad_to_analog

Overview:
- Upstream stage for the 5200 core's player-1 analog inputs (JOY1X/JOY1Y).
- Synthesizes ramped signed 8-bit stick positions from a digital d-pad when no analog stick is active, so keyboard and d-pad pads can play pot-controller games.
- Passes genuine analog data through unchanged when it is present.
- Runs on clk_sys next to the existing mouse emulation; its output feeds the same axis mux.

Parameters:
- RATE_DIV, 4096: clk_sys cycles per ramp tick; must be ≥2.
- STEP, 4: base position change per tick; range 1..127.
- AXIS_MAX, 127: positive saturation. Negative saturation is -AXIS_MAX.

Ports:
- clk_sys, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- joy_in, input, 16: digital buttons. Bit 0 right, 1 left, 2 down, 3 up.
- joya_in, input, 16: analog stick. [7:0] X signed, [15:8] Y signed.
- cpu_halt, input, 1: core halted (OSD/menu). Forces centre.
- enable, input, 1: 0 means pure analog passthrough.
- ax, output, 8: signed X position to the core.
- ay, output, 8: signed Y position to the core.
- synth_active, output, 1: 1 while outputs come from the d-pad synthesizer.

Behaviour:
- Reset: ax=0, ay=0, synth_active=0, tick counter=0, both axis FSMs in CENTRE, internal positions=0.
- Tick generator: counter runs 0..RATE_DIV-1 and wraps. tick=1 for one cycle when counter==RATE_DIV-1. Counter is free-running and is not cleared by source changes.
- Source select, registered, 1-cycle latency from inputs to ax/ay:
  - If joya_in!=0, or enable=0: ax=joya_in[7:0], ay=joya_in[15:8], synth_active=0. Both FSMs are forced to CENTRE with position 0.
  - Otherwise ax/ay = internal X/Y positions and synth_active=1.
- cpu_halt=1 has priority over everything: positions forced to 0, FSMs forced to CENTRE, ax=ay=0, synth_active=0.
- Per-axis FSM, identical for X (pos dir=right, neg dir=left) and Y (pos=down, neg=up). "Held" means exactly one of the two direction bits is set; both set or neither set counts as released.
  - CENTRE: position=0. Pos held → DRIVE_POS. Neg held → DRIVE_NEG. Transition happens immediately; position first changes on the next tick.
  - DRIVE_POS: on tick, pos=min(pos+step, AXIS_MAX). Neg held → pos set to 0 in the same cycle, go to DRIVE_NEG (reversal snaps through centre). Released → RETURN.
  - DRIVE_NEG: mirror of DRIVE_POS. Saturates at -AXIS_MAX.
  - RETURN: on tick, move pos toward 0 by step without overshoot (|pos|≤step gives 0). Reaching 0 → CENTRE. Pos or neg held → DRIVE_POS or DRIVE_NEG from the current position; reversal rule still applies.
- Arithmetic: 9-bit signed internal sum, clamped before truncation to 8 bits. No wrap-around is ever permitted.
- Simultaneous tick and state transition: the transition wins and no step is applied that cycle.
- Reset mid-ramp: all state returns to reset values on the next edge.

Optional Feature:
- Macro DPAD_ANALOG_ACCEL_EN.
- Defined:
  - Each axis keeps a 3-bit hold counter, incremented on every tick while in the same DRIVE state.
  - step=STEP for counts 0-7 and 2*STEP after 8 ticks. Count saturates; a further 8 ticks gives 4*STEP as the cap.
  - Counter is cleared on any state change.
  - RETURN always uses STEP.
- Undefined: step is always STEP and no hold counter is synthesized.

Test Plan:
- Reset, then right held with RATE_DIV=4, STEP=4 → ax=4,8,12,… one per tick; saturates at 127 after 32 ticks; ay=0; synth_active=1.
- Release right at ax=10 → RETURN: ax=6,2,0 on consecutive ticks, then CENTRE; never negative.
- Hold right to ax=40, then press left alone → ax=0 next cycle, then -4,-8 per tick. Left+right pressed together → treated as release, ax ramps to 0.
- Synth at ax=60, then joya_in=16'h2010 → ax=8'h10, ay=8'h20 after 1 cycle, synth_active=0. joya_in returns to 0 → ax=0 (position was cleared).
- cpu_halt=1 while up held at ay=-80 → ay=0 next cycle and stays 0 while halted. Deassert → ramp restarts from 0.
- With DPAD_ANALOG_ACCEL_EN defined, STEP=2, hold right → 8 steps of 2 (ax=16), then steps of 4, then steps of 8, capped at 127.

Source files
------------

// File: rtl/dpad_to_analog.sv
// D-pad to analog stick synthesizer for the 5200 player-1 pot inputs, with analog passthrough.
// Optional hold-time acceleration of the ramp step is enabled by defining DPAD_ANALOG_ACCEL_EN.

module dpad_axis #(
    parameter int STEP     = 4,
    parameter int AXIS_MAX = 127
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              tick,
    input  logic              force_centre,
    input  logic              pos_btn,
    input  logic              neg_btn,
    output logic signed [7:0] pos_next
);

`ifdef DPAD_ANALOG_ACCEL_EN
    // Accelerated steps reach 4*STEP, so the sum needs headroom beyond 9 bits.
    localparam int SUM_W = 11;
`else
    localparam int SUM_W = 9;
`endif

    localparam logic signed [SUM_W-1:0] MAX_S  = SUM_W'(AXIS_MAX);
    localparam logic signed [SUM_W-1:0] MIN_S  = -MAX_S;
    localparam logic signed [SUM_W-1:0] STEP_S = SUM_W'(STEP);

    typedef enum logic [1:0] {
        ST_CENTRE,
        ST_DRIVE_POS,
        ST_DRIVE_NEG,
        ST_RETURN
    } axis_state_e;

    axis_state_e             state_q, state_d;
    logic signed [7:0]       pos_q, pos_d;
    logic                    pos_only, neg_only;
    logic signed [SUM_W-1:0] pos_ext, drive_step;
    logic signed [SUM_W-1:0] sum_up, sum_dn, ret_dn, ret_up;
    logic signed [7:0]       up_sat, dn_sat, ret_val;

    // Both direction bits together count as a release, same as neither.
    assign pos_only = pos_btn & ~neg_btn;
    assign neg_only = neg_btn & ~pos_btn;

`ifdef DPAD_ANALOG_ACCEL_EN
    localparam logic signed [SUM_W-1:0] STEP2_S = SUM_W'(2 * STEP);
    localparam logic signed [SUM_W-1:0] STEP4_S = SUM_W'(4 * STEP);

    logic [2:0] hold_q, hold_d;
    logic [1:0] lvl_q, lvl_d;
    logic       drive_tick;

    assign drive_tick = tick & ~force_centre &
                        (((state_q == ST_DRIVE_POS) & pos_only) |
                         ((state_q == ST_DRIVE_NEG) & neg_only));

    always_comb begin
        case (lvl_q)
            2'd0:    drive_step = STEP_S;
            2'd1:    drive_step = STEP2_S;
            default: drive_step = STEP4_S;
        endcase
    end

    // Every eighth tick held in one DRIVE state raises the level, capped at 4*STEP.
    always_comb begin
        hold_d = hold_q;
        lvl_d  = lvl_q;
        if (force_centre || (state_d != state_q)) begin
            hold_d = '0;
            lvl_d  = '0;
        end else if (drive_tick) begin
            hold_d = hold_q + 3'd1;
            if ((hold_q == 3'd7) && (lvl_q != 2'd2))
                lvl_d = lvl_q + 2'd1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hold_q <= '0;
            lvl_q  <= '0;
        end else begin
            hold_q <= hold_d;
            lvl_q  <= lvl_d;
        end
    end
`else
    assign drive_step = STEP_S;
`endif

    assign pos_ext = {{(SUM_W-8){pos_q[7]}}, pos_q};
    assign sum_up  = pos_ext + drive_step;
    assign sum_dn  = pos_ext - drive_step;
    assign ret_dn  = pos_ext - STEP_S;
    assign ret_up  = pos_ext + STEP_S;

    // Clamp in the wide domain before truncating so the position can never wrap.
    assign up_sat = (sum_up > MAX_S) ? MAX_S[7:0] : sum_up[7:0];
    assign dn_sat = (sum_dn < MIN_S) ? MIN_S[7:0] : sum_dn[7:0];

    always_comb begin
        ret_val = '0;
        if (!pos_q[7] && (pos_ext > STEP_S))
            ret_val = ret_dn[7:0];
        else if (pos_q[7] && (pos_ext < -STEP_S))
            ret_val = ret_up[7:0];
    end

    // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        if (force_centre) begin
            state_d = ST_CENTRE;
            pos_d   = '0;
        end else begin
            case (state_q)
                ST_CENTRE: begin
                    pos_d = '0;
                    if (pos_only)
                        state_d = ST_DRIVE_POS;
                    else if (neg_only)
                        state_d = ST_DRIVE_NEG;
                end
                ST_DRIVE_POS: begin
                    if (neg_only) begin
                        pos_d   = '0;
                        state_d = ST_DRIVE_NEG;
                    end else if (!pos_only)
                        state_d = ST_RETURN;
                    else if (tick)
                        pos_d = up_sat;
                end
                ST_DRIVE_NEG: begin
                    if (pos_only) begin
                        pos_d   = '0;
                        state_d = ST_DRIVE_POS;
                    end else if (!neg_only)
                        state_d = ST_RETURN;
                    else if (tick)
                        pos_d = dn_sat;
                end
                ST_RETURN: begin
                    // Re-pressing resumes from the current position unless it lies on the far side.
                    if (pos_only) begin
                        if (pos_q[7])
                            pos_d = '0;
                        state_d = ST_DRIVE_POS;
                    end else if (neg_only) begin
                        if (!pos_q[7] && (pos_q != '0))
                            pos_d = '0;
                        state_d = ST_DRIVE_NEG;
                    end else if (pos_q == '0)
                        state_d = ST_CENTRE;
                    else if (tick) begin
                        pos_d = ret_val;
                        if (ret_val == '0)
                            state_d = ST_CENTRE;
                    end
                end
                default: begin
                    state_d = ST_CENTRE;
                    pos_d   = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= ST_CENTRE;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
        end
    end

    assign pos_next = pos_d;

endmodule

module dpad_to_analog #(
    parameter int RATE_DIV = 4096,
    parameter int STEP     = 4,
    parameter int AXIS_MAX = 127
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [15:0]       joy_in,
    input  logic [15:0]       joya_in,
    input  logic              cpu_halt,
    input  logic              enable,
    output logic signed [7:0] ax,
    output logic signed [7:0] ay,
    output logic              synth_active
);

    localparam int CNT_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

    logic [CNT_W-1:0]  tick_cnt;
    logic              tick;
    logic              passthrough, force_centre;
    logic signed [7:0] x_next, y_next;
    logic              unused_joy;

    assign unused_joy = ^joy_in[15:4];

    // Free-running ramp timebase; source or button changes never realign it.
    assign tick = (tick_cnt == CNT_W'(RATE_DIV - 1));

    always_ff @(posedge clk_sys) begin
        if (reset)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    assign passthrough  = (joya_in != '0) | ~enable;
    assign force_centre = cpu_halt | passthrough;

    dpad_axis #(
        .STEP     (STEP),
        .AXIS_MAX (AXIS_MAX)
    ) u_axis_x (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .tick         (tick),
        .force_centre (force_centre),
        .pos_btn      (joy_in[0]),
        .neg_btn      (joy_in[1]),
        .pos_next     (x_next)
    );

    dpad_axis #(
        .STEP     (STEP),
        .AXIS_MAX (AXIS_MAX)
    ) u_axis_y (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .tick         (tick),
        .force_centre (force_centre),
        .pos_btn      (joy_in[2]),
        .neg_btn      (joy_in[3]),
        .pos_next     (y_next)
    );

    // Outputs take the axes' next positions so a source change shows up after exactly one edge.
    always_ff @(posedge clk_sys) begin
        if (reset || cpu_halt) begin
            ax           <= '0;
            ay           <= '0;
            synth_active <= 1'b0;
        end else if (passthrough) begin
            ax           <= joya_in[7:0];
            ay           <= joya_in[15:8];
            synth_active <= 1'b0;
        end else begin
            ax           <= x_next;
            ay           <= y_next;
            synth_active <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dpad_to_analog.sv
// Bench for dpad_to_analog: per-cycle scoreboard against a behavioural model plus hand-computed vectors.
// Built with DPAD_ANALOG_ACCEL_EN it also checks the accelerated ramp sequence.

module tb_dpad_to_analog;

    localparam int RATE_DIV = 4;
    localparam int STEP     = 4;
    localparam int AXIS_MAX = 127;

`ifdef DPAD_ANALOG_ACCEL_EN
    localparam int ACCEL = 1;
`else
    localparam int ACCEL = 0;
`endif

    localparam int M_CENTRE = 0;
    localparam int M_POS    = 1;
    localparam int M_NEG    = 2;
    localparam int M_RET    = 3;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic [15:0]       joy_in;
    logic [15:0]       joya_in;
    logic              cpu_halt;
    logic              enable;
    logic signed [7:0] ax;
    logic signed [7:0] ay;
    logic              synth_active;

    dpad_to_analog #(
        .RATE_DIV (RATE_DIV),
        .STEP     (STEP),
        .AXIS_MAX (AXIS_MAX)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .joy_in       (joy_in),
        .joya_in      (joya_in),
        .cpu_halt     (cpu_halt),
        .enable       (enable),
        .ax           (ax),
        .ay           (ay),
        .synth_active (synth_active)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int ax;
        int ay;
        int synth;
    } out_t;

    out_t sb_q[$];

    typedef struct {
        logic        rst;
        logic [15:0] joy;
        logic [15:0] joya;
        logic        halt;
        logic        en;
        int          n;
        int          ax;
        int          ay;
        int          synth;
    } vec_t;

    vec_t vecs[$];

    int m_cnt;
    int m_st[2];
    int m_pos[2];
    int m_hold[2];

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int drive_step(input int hold);
        int lvl;
        lvl = hold / 8;
        if (lvl > 2)
            lvl = 2;
        return STEP * (1 << (lvl * ACCEL));
    endfunction

    task automatic model_axis(input int a, input bit pb, input bit nb, input bit tk);
        bit po, no;
        int prev, v;
        po   = pb && !nb;
        no   = nb && !pb;
        prev = m_st[a];
        case (m_st[a])
            M_CENTRE: begin
                m_pos[a] = 0;
                if (po) m_st[a] = M_POS;
                else if (no) m_st[a] = M_NEG;
            end
            M_POS: begin
                if (no) begin m_pos[a] = 0; m_st[a] = M_NEG; end
                else if (!po) m_st[a] = M_RET;
                else if (tk) begin
                    v = m_pos[a] + drive_step(m_hold[a]);
                    m_pos[a] = (v > AXIS_MAX) ? AXIS_MAX : v;
                    m_hold[a]++;
                end
            end
            M_NEG: begin
                if (po) begin m_pos[a] = 0; m_st[a] = M_POS; end
                else if (!no) m_st[a] = M_RET;
                else if (tk) begin
                    v = m_pos[a] - drive_step(m_hold[a]);
                    m_pos[a] = (v < -AXIS_MAX) ? -AXIS_MAX : v;
                    m_hold[a]++;
                end
            end
            default: begin
                if (po) begin
                    if (m_pos[a] < 0) m_pos[a] = 0;
                    m_st[a] = M_POS;
                end else if (no) begin
                    if (m_pos[a] > 0) m_pos[a] = 0;
                    m_st[a] = M_NEG;
                end else if (m_pos[a] == 0) m_st[a] = M_CENTRE;
                else if (tk) begin
                    if (m_pos[a] > STEP) m_pos[a] -= STEP;
                    else if (m_pos[a] < -STEP) m_pos[a] += STEP;
                    else m_pos[a] = 0;
                    if (m_pos[a] == 0) m_st[a] = M_CENTRE;
                end
            end
        endcase
        if (m_st[a] != prev)
            m_hold[a] = 0;
    endtask

    // One clock: drive inputs, predict the output after the edge, then compare it #1 later.
    task automatic cycle(input logic rst, input logic [15:0] joy, input logic [15:0] joya,
                         input logic halt, input logic en);
        out_t e, got;
        bit   tk, frc;
        reset    = rst;
        joy_in   = joy;
        joya_in  = joya;
        cpu_halt = halt;
        enable   = en;
        if (rst) begin
            m_cnt = 0;
            for (int a = 0; a < 2; a++) begin
                m_st[a] = M_CENTRE; m_pos[a] = 0; m_hold[a] = 0;
            end
            e = '{0, 0, 0};
        end else begin
            tk    = (m_cnt == RATE_DIV - 1);
            m_cnt = tk ? 0 : m_cnt + 1;
            frc   = halt || !en || (joya != 16'h0);
            if (frc) begin
                for (int a = 0; a < 2; a++) begin
                    m_st[a] = M_CENTRE; m_pos[a] = 0; m_hold[a] = 0;
                end
            end else begin
                model_axis(0, joy[0], joy[1], tk);
                model_axis(1, joy[2], joy[3], tk);
            end
            if (halt)
                e = '{0, 0, 0};
            else if (frc)
                e = '{int'($signed(joya[7:0])), int'($signed(joya[15:8])), 0};
            else
                e = '{m_pos[0], m_pos[1], 1};
        end
        sb_q.push_back(e);
        @(posedge clk_sys);
        #1;
        got = sb_q.pop_front();
        check("sb_ax", ax, got.ax);
        check("sb_ay", ay, got.ay);
        check("sb_synth", {31'd0, synth_active}, got.synth);
    endtask

    function automatic void add(input logic rst, input logic [15:0] joy, input logic [15:0] joya,
                                input logic halt, input logic en, input int n,
                                input int eax, input int eay, input int es);
        vec_t v;
        v = '{rst, joy, joya, halt, en, n, eax, eay, es};
        vecs.push_back(v);
    endfunction

`ifdef DPAD_ANALOG_ACCEL_EN
    int exp_acc[18] = '{4, 8, 12, 16, 20, 24, 28, 32, 40, 48, 56, 64, 72, 80, 88, 96, 112, 127};
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Ramp, release, reversal and saturation after reset; tick edges fall every 4th cycle.
        add(0, 16'h1, 16'h0,    0, 1,   3,    0,    0, 1);
        add(0, 16'h1, 16'h0,    0, 1,   1,    4,    0, 1);
        add(0, 16'h1, 16'h0,    0, 1,   8,   12,    0, 1);
        add(0, 16'h0, 16'h0,    0, 1,   1,   12,    0, 1);
        add(0, 16'h0, 16'h0,    0, 1,   3,    8,    0, 1);
        add(0, 16'h0, 16'h0,    0, 1,   4,    4,    0, 1);
        add(0, 16'h0, 16'h0,    0, 1,   4,    0,    0, 1);
        add(0, 16'h0, 16'h0,    0, 1,   4,    0,    0, 1);
        add(0, 16'h1, 16'h0,    0, 1,   4,    4,    0, 1);
        add(0, 16'h1, 16'h0,    0, 1,   3,    4,    0, 1);
        add(0, 16'h0, 16'h0,    0, 1,   1,    4,    0, 1);
        add(0, 16'h0, 16'h0,    0, 1,   4,    0,    0, 1);
        add(0, 16'h1, 16'h0,    0, 1,   4,    4,    0, 1);
        add(0, 16'h1, 16'h0,    0, 1,  36,   40,    0, 1);
        add(0, 16'h2, 16'h0,    0, 1,   1,    0,    0, 1);
        add(0, 16'h2, 16'h0,    0, 1,   3,   -4,    0, 1);
        add(0, 16'h2, 16'h0,    0, 1,   4,   -8,    0, 1);
        add(0, 16'h3, 16'h0,    0, 1,   1,   -8,    0, 1);
        add(0, 16'h3, 16'h0,    0, 1,   3,   -4,    0, 1);
        add(0, 16'h3, 16'h0,    0, 1,   4,    0,    0, 1);
        add(0, 16'h8, 16'h0,    0, 1,   4,    0,   -4, 1);
        add(0, 16'h8, 16'h2010, 0, 1,   1,   16,   32, 0);
        add(0, 16'h8, 16'h0,    0, 1,   1,    0,    0, 1);
        add(0, 16'h8, 16'h0,    0, 0,   1,    0,    0, 0);
        add(0, 16'h8, 16'h0,    0, 1,   1,    0,    0, 1);
        add(0, 16'h8, 16'h0,    0, 1,   4,    0,   -4, 1);
        add(0, 16'h8, 16'h0,    1, 1,   1,    0,    0, 0);
        add(0, 16'h8, 16'h0,    1, 1,   7,    0,    0, 0);
        add(0, 16'h8, 16'h0,    0, 1,   1,    0,    0, 1);
        add(0, 16'h8, 16'h0,    0, 1,   3,    0,   -4, 1);
        add(0, 16'h8, 16'h0,    0, 1, 124,    0, -127, 1);
        add(0, 16'h4, 16'h0,    0, 1,   1,    0,    0, 1);
        add(0, 16'h5, 16'h0,    0, 1,   3,    4,    4, 1);
        add(0, 16'h5, 16'h0,    0, 1, 124,  127,  127, 1);
        add(0, 16'h5, 16'h0,    0, 1,   4,  127,  127, 1);
        add(1, 16'h5, 16'h0,    0, 1,   1,    0,    0, 0);
        add(0, 16'h1, 16'h0,    0, 1,   4,    4,    0, 1);

        repeat (3) cycle(1, 16'h0, 16'h0, 1'b0, 1'b1);
        check("reset_ax", ax, 0);
        check("reset_ay", ay, 0);
        check("reset_synth", {31'd0, synth_active}, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            repeat (vecs[i].n)
                cycle(vecs[i].rst, vecs[i].joy, vecs[i].joya, vecs[i].halt, vecs[i].en);
`ifndef DPAD_ANALOG_ACCEL_EN
            check($sformatf("vec%0d_ax", i), ax, vecs[i].ax);
            check($sformatf("vec%0d_ay", i), ay, vecs[i].ay);
            check($sformatf("vec%0d_synth", i), {31'd0, synth_active}, vecs[i].synth);
`endif
        end

`ifdef DPAD_ANALOG_ACCEL_EN
        cycle(1, 16'h0, 16'h0, 1'b0, 1'b1);
        for (int t = 0; t < 18; t++) begin
            repeat (RATE_DIV) cycle(0, 16'h1, 16'h0, 1'b0, 1'b1);
            check($sformatf("accel_tick%0d", t + 1), ax, exp_acc[t]);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
